// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings for load/store size and signedness
//   - FSM state type
//   - illegal-access classification helper
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // An access is illegal if it is both a read and a write, uses an undefined
  // funct3 for its direction, or is not naturally aligned for its size.
  // funct3[1:0] encodes size for all legal codes (00 byte, 01 half, 10 word).
  function automatic logic is_illegal(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad_f3;
    logic misalign;
    bad_f3   = (rd && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
               (wr && !(f3 == LS_B || f3 == LS_H || f3 == LS_W));
    misalign = ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    return (rd && wr) || bad_f3 || misalign;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// load_extend: combinational lane select and sign/zero extension of a bus
// read word.
//   funct3    : load type (LB/LH/LW/LBU/LHU)
//   off       : byte offset within the word
//   bus_rdata : raw 32-bit word from the bus
//   result    : extended 32-bit load value (0 for undefined funct3)
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (off)
      2'd0: begin byte_s = bus_rdata[7:0];   half_s = bus_rdata[15:0];  end
      2'd1: begin byte_s = bus_rdata[15:8];  half_s = bus_rdata[23:8];  end
      2'd2: begin byte_s = bus_rdata[23:16]; half_s = bus_rdata[31:16]; end
      // Offset 3 never carries a legal halfword; the upper half is a don't-care.
      2'd3: begin byte_s = bus_rdata[31:24]; half_s = bus_rdata[31:16]; end
      default: begin byte_s = 8'h00; half_s = 16'h0000; end
    endcase
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      LS_B:    result = {{24{byte_s[7]}}, byte_s};
      LS_H:    result = {{16{half_s[15]}}, half_s};
      LS_W:    result = bus_rdata;
      LS_BU:   result = {24'h00_0000, byte_s};
      LS_HU:   result = {16'h0000, half_s};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving a word-addressed req/gnt/rvalid data bus.
//   core side : mem_read, mem_write, ls_funct3, addr, wdata -> stall, rdata,
//               access_err
//   bus side  : bus_req, bus_we, bus_addr, bus_be, bus_wdata -> bus_gnt,
//               bus_rvalid, bus_rdata
// Illegal accesses are flagged combinationally in IDLE and never reach the bus.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_t  state_r;
  lsu_state_t  state_next_s;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic        op_s;
  logic        illegal_s;
  logic        accept_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [31:0] ext_s;

  assign op_s      = mem_read | mem_write;
  assign illegal_s = is_illegal(mem_read, mem_write, ls_funct3, addr[1:0]);

  // Next-state logic and combinational core-side outputs.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    access_err   = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_s && illegal_s) begin
          access_err = 1'b1;
        end else if (op_s) begin
          accept_s     = 1'b1;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) state_next_s = WAIT;
        else         state_next_s = REQ;
      end
      WAIT: begin
        if (bus_rvalid) state_next_s = DONE;
        else            state_next_s = WAIT;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
    stall = op_s && (state_r != DONE) && !((state_r == IDLE) && illegal_s);
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_s = 4'b0000;
    wd_s = wdata;
    case (ls_funct3[1:0])
      2'b00: begin be_s = 4'b0001 << addr[1:0]; wd_s = {4{wdata[7:0]}};  end
      2'b01: begin be_s = 4'b0011 << addr[1:0]; wd_s = {2{wdata[15:0]}}; end
      2'b10: begin be_s = 4'b1111;              wd_s = wdata;            end
      default: begin be_s = 4'b0000;            wd_s = wdata;            end
    endcase
  end

  load_extend u_load_extend (
    .funct3    (funct3_r),
    .off       (off_r),
    .bus_rdata (bus_rdata),
    .result    (ext_s)
  );

  // State register, latched request fields and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0000_0000;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0000_0000;
      rdata     <= 32'h0000_0000;
      funct3_r  <= 3'b000;
      off_r     <= 2'b00;
    end else begin
      state_r <= state_next_s;
      // Request is high exactly while the FSM sits in REQ.
      bus_req <= (state_next_s == REQ);
      if (accept_s) begin
        bus_addr  <= {addr[31:2], 2'b00};
        bus_we    <= mem_write;
        bus_be    <= be_s;
        bus_wdata <= wd_s;
        funct3_r  <= ls_funct3;
        off_r     <= addr[1:0];
      end
      // A store's rvalid is only an ack; rdata keeps the last load value.
      if ((state_r == WAIT) && bus_rvalid && !bus_we) begin
        rdata <= ext_s;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  ls_funct3;
  logic [31:0] addr, wdata;
  logic        stall, access_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Captured during accesses.
  int          stall_cnt;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .ls_funct3(ls_funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .access_err(access_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: gnt after gd wait cycles in REQ, rvalid after rd
  // wait cycles in WAIT. Counts stall cycles and records bus fields.
  task automatic do_access(input string tag, input logic rd_op, input logic wr_op,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] resp);
    stall_cnt = 0;
    mem_read = rd_op; mem_write = wr_op; ls_funct3 = f3; addr = a; wdata = wd;
    #1;
    if (stall) stall_cnt++;
    tick();
    cap_addr = bus_addr; cap_be = bus_be; cap_we = bus_we; cap_wdata = bus_wdata;
    for (int i = 0; i <= gd; i++) begin
      chk({tag, "_req_hi"}, {31'd0, bus_req}, 32'd1);
      if (i == gd) bus_gnt = 1'b1;
      if (stall) stall_cnt++;
      tick();
      bus_gnt = 1'b0;
    end
    chk({tag, "_req_lo"}, {31'd0, bus_req}, 32'd0);
    for (int i = 0; i <= rd; i++) begin
      if (i == rd) begin bus_rvalid = 1'b1; bus_rdata = resp; end
      if (stall) stall_cnt++;
      tick();
      bus_rvalid = 1'b0;
    end
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    cap_rdata = rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; ls_funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_we",    {31'd0, bus_we}, 32'd0);
    chk("rst_addr",  bus_addr, 32'h0);
    chk("rst_be",    {28'd0, bus_be}, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err",   {31'd0, access_err}, 32'd0);

    // LW 0x100, minimum latency
    do_access("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF);
    chk("lw_addr",  cap_addr, 32'h0000_0100);
    chk("lw_be",    {28'd0, cap_be}, 32'h0000_000F);
    chk("lw_we",    {31'd0, cap_we}, 32'd0);
    chk("lw_stall", stall_cnt, 32'd3);
    chk("lw_rdata", cap_rdata, 32'hDEAD_BEEF);

    // LB / LBU at offset 3
    do_access("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lb_be",    {28'd0, cap_be}, 32'h0000_0008);
    chk("lb_addr",  cap_addr, 32'h0000_0100);
    chk("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_0000);
    chk("lbu_rdata", cap_rdata, 32'h0000_0080);

    // SH at 0x202
    do_access("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 0, 32'h0);
    chk("sh_we",    {31'd0, cap_we}, 32'd1);
    chk("sh_addr",  cap_addr, 32'h0000_0200);
    chk("sh_be",    {28'd0, cap_be}, 32'h0000_000C);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_rdata_kept", rdata, 32'h0000_0080);

    // SB at 0x101
    do_access("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 0, 0, 32'h0);
    chk("sb_be",    {28'd0, cap_be}, 32'h0000_0002);
    chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);

    // Misaligned LW: error, no stall, no bus activity
    mem_read = 1'b1; ls_funct3 = 3'b010; addr = 32'h0000_0102;
    #1;
    chk("mis_err",   {31'd0, access_err}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_req", {31'd0, bus_req}, 32'd0);
    end
    mem_read = 1'b0;
    #1;
    chk("mis_err_clr", {31'd0, access_err}, 32'd0);

    // Store with funct3 011
    mem_write = 1'b1; ls_funct3 = 3'b011; addr = 32'h0000_0100;
    #1;
    chk("sf3_err",   {31'd0, access_err}, 32'd1);
    chk("sf3_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sf3_req", {31'd0, bus_req}, 32'd0);
    mem_write = 1'b0;

    // Both read and write: illegal
    mem_read = 1'b1; mem_write = 1'b1; ls_funct3 = 3'b010; addr = 32'h0000_0100;
    #1;
    chk("rw_err", {31'd0, access_err}, 32'd1);
    tick();
    chk("rw_req", {31'd0, bus_req}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;

    // LH with gnt delayed 3 and rvalid delayed 2
    do_access("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0106, 32'h0, 3, 2, 32'h8001_1234);
    chk("lh_stall", stall_cnt, 32'd8);
    chk("lh_be",    {28'd0, cap_be}, 32'h0000_000C);
    chk("lh_rdata", cap_rdata, 32'hFFFF_8001);

    // LHU at offset 0
    do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0, 1, 0, 32'h1234_F00D);
    chk("lhu_rdata", cap_rdata, 32'h0000_F00D);
    chk("lhu_stall", stall_cnt, 32'd4);

    // Reset in WAIT, then a stale rvalid
    mem_read = 1'b1; ls_funct3 = 3'b010; addr = 32'h0000_0400;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    tick();
    bus_rvalid = 1'b0;
    chk("stale_rdata", rdata, 32'h0);
    chk("stale_req",   {31'd0, bus_req}, 32'd0);
    // Op now present: unit must be in IDLE (stall high, not a DONE cycle)
    mem_read = 1'b1; ls_funct3 = 3'b010; addr = 32'h0000_0500;
    #1;
    chk("post_rst_idle", {31'd0, stall}, 32'd1);
    mem_read = 1'b0;
    do_access("lw2", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 0, 0, 32'h1122_3344);
    chk("lw2_addr",  cap_addr, 32'h0000_0500);
    chk("lw2_stall", stall_cnt, 32'd3);
    chk("lw2_rdata", cap_rdata, 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
